// File: rtl/ctrl_pkg.sv
// Shared opcode map, FSM state encoding and control payload types.
package ctrl_pkg;

   localparam logic [3:0] OP_ADD     = 4'b0000;
   localparam logic [3:0] OP_ADDBASE = 4'b0001;
   localparam logic [3:0] OP_SUB     = 4'b0010;
   localparam logic [3:0] OP_ADDI    = 4'b0011;
   localparam logic [3:0] OP_MUL     = 4'b0100;
   localparam logic [3:0] OP_AND     = 4'b0101;
   localparam logic [3:0] OP_SHIFT   = 4'b0110;
   localparam logic [3:0] OP_LOAD    = 4'b0111;
   localparam logic [3:0] OP_LDI     = 4'b1000;
   localparam logic [3:0] OP_STORE   = 4'b1001;
   localparam logic [3:0] OP_STI     = 4'b1010;
   localparam logic [3:0] OP_CLEAR   = 4'b1011;
   localparam logic [3:0] OP_CMP     = 4'b1101;
   localparam logic [3:0] OP_HALT    = 4'b1111;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_MEM_PTR,
      ST_MEM,
      ST_EXEC,
      ST_WB,
      ST_HALT
   } state_t;

   // Instruction class produced by the opcode decoder
   typedef struct packed {
      logic is_r_type;
      logic alu_src;
      logic mem_to_reg;
      logic is_load;
      logic is_store;
      logic is_indirect;
      logic is_mul;
      logic is_addbase;
      logic is_halt;
      logic illegal;
   } dec_t;

   // Registered control outputs toward the datapath
   typedef struct packed {
      logic instr_ready;
      logic mem_req;
      logic mem_we;
      logic mem_addr_sel;
      logic pc_write;
      logic reg_write;
      logic mem_to_reg;
      logic alu_src;
      logic reg_dest;
      logic is_r_type;
      logic illegal_op;
      logic halted;
      logic busy;
   } ctrl_out_t;

   localparam ctrl_out_t OUT_RESET = '{instr_ready: 1'b1, default: 1'b0};

   // Width of the multiplier down-counter, which holds MUL_LATENCY-1
   function automatic int unsigned cnt_width(input int unsigned latency);
      return (latency > 2) ? $clog2(latency) : 1;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W    = 4,
   parameter int unsigned INDIRECT_EN = 1
) (
   input  logic [OPCODE_W-1:0] opcode,
   output dec_t                dec
);

   logic       hi_set;
   logic [3:0] lo;

   // Classify the low nibble; any set bit above bit 3 makes the opcode illegal
   always_comb begin
      dec    = '0;
      lo     = opcode[3:0];
      hi_set = (OPCODE_W > 4) ? ((opcode >> 4) != '0) : 1'b0;
      if (hi_set) begin
         dec.illegal = 1'b1;
      end else begin
         case (lo)
            OP_ADD, OP_SUB, OP_AND, OP_SHIFT, OP_CLEAR, OP_CMP: dec.is_r_type = 1'b1;
            OP_MUL: begin
               dec.is_r_type = 1'b1;
               dec.is_mul    = 1'b1;
            end
            OP_ADDI:    dec.alu_src    = 1'b1;
            OP_ADDBASE: dec.is_addbase = 1'b1;
            OP_LOAD: begin
               dec.is_load    = 1'b1;
               dec.mem_to_reg = 1'b1;
            end
            OP_LDI: begin
               if (INDIRECT_EN != 0) begin
                  dec.is_load     = 1'b1;
                  dec.mem_to_reg  = 1'b1;
                  dec.is_indirect = 1'b1;
               end else begin
                  dec.illegal = 1'b1;
               end
            end
            OP_STORE: dec.is_store = 1'b1;
            OP_STI: begin
               if (INDIRECT_EN != 0) begin
                  dec.is_store    = 1'b1;
                  dec.is_indirect = 1'b1;
               end else begin
                  dec.illegal = 1'b1;
               end
            end
            OP_HALT: dec.is_halt = 1'b1;
            default: dec.illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, write-back.
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W    = 4,
   parameter int unsigned MUL_LATENCY = 3,
   parameter int unsigned INDIRECT_EN = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ack,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_addr_sel,
   output logic                ir_write,
   output logic                pc_write,
   output logic                reg_write,
   output logic                mem_to_reg,
   output logic                alu_src,
   output logic                reg_dest,
   output logic                is_r_type,
   output logic                illegal_op,
   output logic                halted,
   output logic                busy
);

   localparam int unsigned     CNT_W    = cnt_width(MUL_LATENCY);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

   state_t          state, next_state;
   dec_t            dec_in, dec_q, dec_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic            second_pass, second_pass_next;
   logic            active;
   ctrl_out_t       out_q, out_next;

   ctrl_decode #(
      .OPCODE_W    (OPCODE_W),
      .INDIRECT_EN (INDIRECT_EN)
   ) u_decode (
      .opcode (opcode),
      .dec    (dec_in)
   );

   // State, latched decode, multiplier counter and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_FETCH;
         dec_q       <= '0;
         cnt         <= '0;
         second_pass <= 1'b0;
         out_q       <= OUT_RESET;
      end else begin
         state       <= next_state;
         dec_q       <= dec_next;
         cnt         <= cnt_next;
         second_pass <= second_pass_next;
         out_q       <= out_next;
      end
   end

   // Next state, plus outputs derived from the state being entered so they register cleanly
   always_comb begin
      next_state       = state;
      dec_next         = dec_q;
      cnt_next         = cnt;
      second_pass_next = second_pass;
      out_next         = '0;
      active           = 1'b0;

      case (state)
         ST_FETCH: begin
            if (instr_valid) begin
               dec_next         = dec_in;
               second_pass_next = 1'b0;
               next_state       = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (dec_q.illegal) begin
               next_state = ST_FETCH;
            end else if (dec_q.is_halt) begin
               next_state = ST_HALT;
            end else begin
               next_state = ST_EXEC;
               if (dec_q.is_mul) cnt_next = MUL_LOAD;
            end
         end
         ST_EXEC: begin
            if (dec_q.is_mul && (cnt != '0)) begin
               cnt_next = cnt - CNT_W'(1);
            end else if ((dec_q.is_load || dec_q.is_store || dec_q.is_addbase) && !second_pass) begin
               next_state = dec_q.is_indirect ? ST_MEM_PTR : ST_MEM;
            end else begin
               next_state = ST_WB;
            end
         end
         ST_MEM_PTR: begin
            if (mem_ack) next_state = ST_MEM;
         end
         ST_MEM: begin
            if (mem_ack) begin
               if (dec_q.is_addbase) begin
                  next_state       = ST_EXEC;
                  second_pass_next = 1'b1;
               end else begin
                  // loads write back; stores use WB only for the PC advance
                  next_state = ST_WB;
               end
            end
         end
         ST_WB:   next_state = ST_FETCH;
         ST_HALT: next_state = ST_HALT;
         default: next_state = ST_FETCH;
      endcase

      active                = (next_state != ST_FETCH) && (next_state != ST_HALT);
      out_next.instr_ready  = (next_state == ST_FETCH);
      out_next.mem_req      = (next_state == ST_MEM_PTR) || (next_state == ST_MEM);
      out_next.mem_we       = (next_state == ST_MEM) && dec_next.is_store;
      out_next.mem_addr_sel = (next_state == ST_MEM) && dec_next.is_indirect;
      out_next.reg_write    = (next_state == ST_WB) && !dec_next.is_store;
      out_next.illegal_op   = (next_state == ST_DECODE) && dec_next.illegal;
      out_next.pc_write     = (next_state == ST_WB) || out_next.illegal_op;
      out_next.mem_to_reg   = active && dec_next.mem_to_reg;
      out_next.alu_src      = active && dec_next.alu_src;
      out_next.is_r_type    = active && dec_next.is_r_type;
      out_next.reg_dest     = active && dec_next.is_r_type;
      out_next.halted       = (next_state == ST_HALT);
      out_next.busy         = active;
   end

   // Instruction-register latch must coincide with the accepting cycle
   assign ir_write     = (state == ST_FETCH) && instr_valid && !rst;

   assign instr_ready  = out_q.instr_ready;
   assign mem_req      = out_q.mem_req;
   assign mem_we       = out_q.mem_we;
   assign mem_addr_sel = out_q.mem_addr_sel;
   assign pc_write     = out_q.pc_write;
   assign reg_write    = out_q.reg_write;
   assign mem_to_reg   = out_q.mem_to_reg;
   assign alu_src      = out_q.alu_src;
   assign reg_dest     = out_q.reg_dest;
   assign is_r_type    = out_q.is_r_type;
   assign illegal_op   = out_q.illegal_op;
   assign halted       = out_q.halted;
   assign busy         = out_q.busy;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (OPCODE_W=5, MUL_LATENCY=3, indirect enabled).
module tb_multicycle_control_unit;

   localparam int unsigned OW = 5;

   logic          clk;
   logic          rst;
   logic          instr_valid;
   logic          instr_ready;
   logic [OW-1:0] opcode;
   logic          mem_ack;
   logic          mem_req, mem_we, mem_addr_sel;
   logic          ir_write, pc_write, reg_write;
   logic          mem_to_reg, alu_src, reg_dest, is_r_type;
   logic          illegal_op, halted, busy;

   int nvec  = 0;
   int nfail = 0;

   multicycle_control_unit #(
      .OPCODE_W    (OW),
      .MUL_LATENCY (3),
      .INDIRECT_EN (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .opcode       (opcode),
      .mem_ack      (mem_ack),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .reg_write    (reg_write),
      .mem_to_reg   (mem_to_reg),
      .alu_src      (alu_src),
      .reg_dest     (reg_dest),
      .is_r_type    (is_r_type),
      .illegal_op   (illegal_op),
      .halted       (halted),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One instruction: stimulus plus the behaviour it must produce
   typedef struct {
      logic [OW-1:0] op;
      int            delay;   // ack arrives this many cycles after each access starts
      int            lat;     // accept cycle to next instr_ready
      int            rw_cyc;  // reg_write cycle, -1 for none
      int            n_acc;
      logic [1:0]    sel;     // mem_addr_sel per access (bit i = access i)
      logic [1:0]    we;      // mem_we per access
      logic [2:0]    flags;   // {mem_to_reg, alu_src, reg_dest} at the pc_write cycle
      int            ill;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   function automatic vec_t mk(input logic [OW-1:0] op, input int delay, input int lat,
                               input int rw_cyc, input int n_acc, input logic [1:0] sel,
                               input logic [1:0] we, input logic [2:0] flags, input int ill);
      vec_t v;
      v.op = op; v.delay = delay; v.lat = lat; v.rw_cyc = rw_cyc; v.n_acc = n_acc;
      v.sel = sel; v.we = we; v.flags = flags; v.ill = ill;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one instruction, act as the memory, then score the trace
   task automatic run_vec(input vec_t v);
      vec_t e;
      int   irw0, n_irw, n_rw, rw_cyc, n_pc, pc_cyc, n_ill, n_acc, unstable, wt, lat;
      logic [1:0] sel, we;
      logic [2:0] flags;
      logic       in_acc, we0, sel0;
      string      tag;

      sb.push_back(v);
      n_irw = 0; n_rw = 0; rw_cyc = -1; n_pc = 0; pc_cyc = -1; n_ill = 0; n_acc = 0;
      unstable = 0; wt = 0; lat = -1; sel = '0; we = '0; flags = '0;
      in_acc = 1'b0; we0 = 1'b0; sel0 = 1'b0;

      opcode      = v.op;
      instr_valid = 1'b1;
      mem_ack     = 1'b0;
      #1;
      irw0 = int'(ir_write);

      for (int c = 1; c <= 60 && lat < 0; c++) begin
         step();
         instr_valid = 1'b0;
         if (ir_write)   n_irw++;
         if (reg_write)  begin n_rw++; rw_cyc = c; end
         if (pc_write)   begin n_pc++; pc_cyc = c; flags = {mem_to_reg, alu_src, reg_dest}; end
         if (illegal_op) n_ill++;
         if (mem_req) begin
            if (!in_acc) begin
               in_acc = 1'b1; we0 = mem_we; sel0 = mem_addr_sel;
            end else if (mem_we != we0 || mem_addr_sel != sel0) begin
               unstable++;
            end
            if (wt == v.delay) begin
               mem_ack = 1'b1;
               if (n_acc < 2) begin
                  sel[n_acc] = mem_addr_sel;
                  we[n_acc]  = mem_we;
               end
               n_acc++;
               wt = 0;
               in_acc = 1'b0;
            end else begin
               mem_ack = 1'b0;
               wt++;
            end
         end else begin
            mem_ack = 1'b0; in_acc = 1'b0; wt = 0;
         end
         if (instr_ready) lat = c;
      end
      mem_ack = 1'b0;

      e   = sb.pop_front();
      tag = $sformatf("op%b/d%0d", e.op, e.delay);
      chk({tag, " ir_write@0"},      irw0,       1);
      chk({tag, " ir_write_extra"},  n_irw,      0);
      chk({tag, " latency"},         lat,        e.lat);
      chk({tag, " reg_write_count"}, n_rw,       (e.rw_cyc >= 0) ? 1 : 0);
      chk({tag, " reg_write_cycle"}, rw_cyc,     e.rw_cyc);
      chk({tag, " pc_write_count"},  n_pc,       1);
      chk({tag, " pc_write_cycle"},  pc_cyc,     e.lat - 1);
      chk({tag, " illegal_count"},   n_ill,      e.ill);
      chk({tag, " accesses"},        n_acc,      e.n_acc);
      chk({tag, " addr_sel"},        int'(sel),  int'(e.sel));
      chk({tag, " mem_we"},          int'(we),   int'(e.we));
      chk({tag, " flags"},           int'(flags), int'(e.flags));
      chk({tag, " stable_req"},      unstable,   0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] outs;
      int          bad;

      rst = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0; opcode = '0;
      repeat (3) step();
      rst = 1'b0;
      outs = {instr_ready, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write,
              mem_to_reg, alu_src, reg_dest, is_r_type, illegal_op, halted, busy};
      chk("reset_outputs", int'(outs), int'(14'b1000_0000_0000_00));

      //               op        d  lat rw  acc sel    we     flags   ill
      tbl.push_back(mk(5'b00000, 0,  4,  3, 0, 2'b00, 2'b00, 3'b001, 0));
      tbl.push_back(mk(5'b00010, 0,  4,  3, 0, 2'b00, 2'b00, 3'b001, 0));
      tbl.push_back(mk(5'b00101, 0,  4,  3, 0, 2'b00, 2'b00, 3'b001, 0));
      tbl.push_back(mk(5'b00110, 0,  4,  3, 0, 2'b00, 2'b00, 3'b001, 0));
      tbl.push_back(mk(5'b01011, 0,  4,  3, 0, 2'b00, 2'b00, 3'b001, 0));
      tbl.push_back(mk(5'b01101, 0,  4,  3, 0, 2'b00, 2'b00, 3'b001, 0));
      tbl.push_back(mk(5'b00100, 0,  6,  5, 0, 2'b00, 2'b00, 3'b001, 0));
      tbl.push_back(mk(5'b00011, 0,  4,  3, 0, 2'b00, 2'b00, 3'b010, 0));
      tbl.push_back(mk(5'b00001, 1,  7,  6, 1, 2'b00, 2'b00, 3'b000, 0));
      tbl.push_back(mk(5'b00111, 0,  5,  4, 1, 2'b00, 2'b00, 3'b100, 0));
      tbl.push_back(mk(5'b00111, 2,  7,  6, 1, 2'b00, 2'b00, 3'b100, 0));
      tbl.push_back(mk(5'b01000, 2, 10,  9, 2, 2'b10, 2'b00, 3'b100, 0));
      tbl.push_back(mk(5'b01001, 3,  8, -1, 1, 2'b00, 2'b01, 3'b000, 0));
      tbl.push_back(mk(5'b01001, 0,  5, -1, 1, 2'b00, 2'b01, 3'b000, 0));
      tbl.push_back(mk(5'b01010, 1,  8, -1, 2, 2'b10, 2'b10, 3'b000, 0));
      tbl.push_back(mk(5'b01110, 0,  2, -1, 0, 2'b00, 2'b00, 3'b000, 1));
      tbl.push_back(mk(5'b01100, 0,  2, -1, 0, 2'b00, 2'b00, 3'b000, 1));
      tbl.push_back(mk(5'b10001, 0,  2, -1, 0, 2'b00, 2'b00, 3'b000, 1));
      tbl.push_back(mk(5'b10000, 0,  2, -1, 0, 2'b00, 2'b00, 3'b000, 1));
      tbl.push_back(mk(5'b00000, 0,  4,  3, 0, 2'b00, 2'b00, 3'b001, 0));

      foreach (tbl[i]) run_vec(tbl[i]);

      // Reset while a load waits for memory, then a stray ack
      opcode = 5'b00111; instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      bad = 1;
      for (int c = 0; c < 10 && bad != 0; c++) begin
         if (mem_req) bad = 0;
         else step();
      end
      chk("rst_mid_mem reached_mem", bad, 0);
      step();
      rst = 1'b1;
      step();
      chk("rst_mid_mem mem_req",     int'(mem_req),     0);
      chk("rst_mid_mem instr_ready", int'(instr_ready), 1);
      chk("rst_mid_mem busy",        int'(busy),        0);
      chk("rst_mid_mem strobes",     int'({reg_write, pc_write}), 0);
      rst = 1'b0;
      mem_ack = 1'b1;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (c == 1) mem_ack = 1'b0;
         if (reg_write || pc_write || mem_req || !instr_ready || busy) bad++;
      end
      chk("stray_ack_ignored", bad, 0);

      // Halt holds until reset, even with a pending instruction
      opcode = 5'b01111; instr_valid = 1'b1;
      #1;
      chk("halt ir_write@0", int'(ir_write), 1);
      step();
      step();
      chk("halt halted",      int'(halted),      1);
      chk("halt instr_ready", int'(instr_ready), 0);
      chk("halt busy",        int'(busy),        0);
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (instr_ready || ir_write || reg_write || pc_write || mem_req || busy || !halted) bad++;
      end
      chk("halt held", bad, 0);
      instr_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("halt exit halted",      int'(halted),      0);
      chk("halt exit instr_ready", int'(instr_ready), 1);
      run_vec(mk(5'b00010, 0, 4, 3, 0, 2'b00, 2'b00, 3'b001, 0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
